// File: rtl/bab_poly_engine.sv
// rtl/bab_poly_engine.sv - difference engine evaluating a loaded polynomial at point n by repeated addition (optional saturation: BAB_SAT_EN)
module bab_poly_engine #(
    parameter int DATA_W = 16,
    parameter int N_W    = 6,
    parameter int ORDER  = 3,
    parameter int IDX_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [N_W-1:0]    i_n,
    input  logic              i_load,
    input  logic [IDX_W-1:0]  i_load_idx,
    input  logic [DATA_W-1:0] i_load_val,
    output logic [DATA_W-1:0] o_val,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] init_q [0:ORDER];
    logic [DATA_W-1:0] init_d [0:ORDER];
    logic [DATA_W-1:0] d_q    [0:ORDER];
    logic [DATA_W-1:0] d_d    [0:ORDER];
    logic [N_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    // One extra bit per adder exposes the carry-out that drives the overflow flag.
    logic [DATA_W:0]   sum_w  [0:ORDER-1];
    logic [DATA_W-1:0] step_w [0:ORDER-1];
    logic [ORDER-1:0]  carry_w;

    // Difference-column adders: each d[k] absorbs its pre-update neighbour d[k+1].
    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            sum_w[k]   = {1'b0, d_q[k]} + {1'b0, d_q[k+1]};
            carry_w[k] = sum_w[k][DATA_W];
`ifdef BAB_SAT_EN
            step_w[k]  = carry_w[k] ? {DATA_W{1'b1}} : sum_w[k][DATA_W-1:0];
`else
            step_w[k]  = sum_w[k][DATA_W-1:0];
`endif
        end
    end

    // Next-state, datapath and registered-output computation for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    // Start takes priority; a coincident load is dropped.
                    d_d     = init_q;
                    cnt_d   = i_n;
                    ovf_d   = 1'b0;
                    state_d = S_CALC;
                end else if (i_load) begin
                    // Indices beyond ORDER match no register and are ignored.
                    for (int k = 0; k <= ORDER; k++) begin
                        if (i_load_idx == IDX_W'(k)) begin
                            init_d[k] = i_load_val;
                        end
                    end
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    val_d   = d_q[0];
                    state_d = S_DONE;
                end else begin
                    for (int k = 0; k < ORDER; k++) begin
                        d_d[k] = step_w[k];
                    end
                    cnt_d = cnt_q - N_W'(1);
                    if (|carry_w) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (i_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any evaluation and clears the loaded column.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k <= ORDER; k++) begin
                init_q[k] <= '0;
                d_q[k]    <= '0;
            end
            cnt_q   <= '0;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign o_val   = val_q;
    assign o_ready = ready_q;
    assign o_done  = done_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bab_poly_engine.sv
// tb/tb_bab_poly_engine.sv - self-checking bench for bab_poly_engine against a binomial-sum reference
module tb_bab_poly_engine;

    localparam int DW  = 16;
    localparam int NW  = 6;
    localparam int ORD = 3;
    localparam int IW  = 2;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic           i_rst;
    logic           i_start, i_clear, i_load;
    logic [NW-1:0]  i_n;
    logic [IW-1:0]  i_load_idx;
    logic [DW-1:0]  i_load_val;
    logic [DW-1:0]  o_val;
    logic           o_ready, o_done, o_ovf;

    logic           b_start, b_clear, b_load;
    logic [NW-1:0]  b_n;
    logic [IW-1:0]  b_idx;
    logic [DW-1:0]  b_lval;
    logic [DW-1:0]  b_val;
    logic           b_ready, b_done, b_ovf;

    bab_poly_engine #(.DATA_W(DW), .N_W(NW), .ORDER(ORD), .IDX_W(IW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_clear(i_clear),
        .i_n(i_n), .i_load(i_load), .i_load_idx(i_load_idx), .i_load_val(i_load_val),
        .o_val(o_val), .o_ready(o_ready), .o_done(o_done), .o_ovf(o_ovf)
    );

    bab_poly_engine #(.DATA_W(DW), .N_W(NW), .ORDER(2), .IDX_W(IW)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(b_start), .i_clear(b_clear),
        .i_n(b_n), .i_load(b_load), .i_load_idx(b_idx), .i_load_val(b_lval),
        .o_val(b_val), .o_ready(b_ready), .o_done(b_done), .o_ovf(b_ovf)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] m_init  [4];
    logic [DW-1:0] m2_init [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned binom(input int t, input int j);
        longint unsigned r = 1;
        if (j > t) return 0;
        for (int i = 0; i < j; i++) r = r * longint'(t - i) / longint'(i + 1);
        return r;
    endfunction

    // k-th difference after t steps: sum_j C(t,j) * init[k+j], reduced mod 2^DW.
    function automatic logic [DW-1:0] diff_at(input int t, input int k, input int ord,
                                              input logic [DW-1:0] ini [4]);
        longint unsigned s = 0;
        for (int j = 0; j <= ord - k; j++) s += binom(t, j) * longint'(ini[k+j]);
        return s[DW-1:0];
    endfunction

    function automatic bit ovf_model(input int n, input int ord, input logic [DW-1:0] ini [4]);
        for (int t = 0; t < n; t++)
            for (int k = 0; k < ord; k++)
                if (int'(diff_at(t, k, ord, ini)) + int'(diff_at(t, k + 1, ord, ini)) >= (1 << DW))
                    return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_load(input int idx, input logic [DW-1:0] v);
        @(negedge i_clk);
        i_load = 1'b1; i_load_idx = IW'(idx); i_load_val = v;
        @(negedge i_clk);
        i_load = 1'b0;
        if (idx <= ORD) m_init[idx] = v;
    endtask

    task automatic run_eval(input int n, input bit load_calc, input bit start_done, input bit load_start);
        logic [DW-1:0] exp_v, prev;
        bit            exp_o, held;
        int            cycles;
        exp_v = diff_at(n, 0, ORD, m_init);
        exp_o = ovf_model(n, ORD, m_init);
`ifdef BAB_SAT_EN
        if (exp_o) exp_v = {DW{1'b1}};
`endif
        @(negedge i_clk);
        prev = o_val;
        i_start = 1'b1; i_n = NW'(n);
        if (load_start) begin
            i_load = 1'b1; i_load_idx = '0; i_load_val = ~m_init[0];
        end
        @(posedge i_clk); #1;
        i_start = 1'b0; i_load = 1'b0;
        chk($sformatf("ready_low n=%0d", n), o_ready, 0);
        cycles = 0; held = 1'b1;
        while (!o_done && cycles < 100) begin
            if (load_calc && cycles == 0) begin
                i_load = 1'b1; i_load_idx = 2'd1; i_load_val = DW'($urandom);
            end
            @(posedge i_clk); #1;
            i_load = 1'b0;
            cycles++;
            if (!o_done && o_val !== prev) held = 1'b0;
        end
        chk($sformatf("latency n=%0d", n), cycles, n + 1);
        chk($sformatf("val_held n=%0d", n), held, 1);
        chk($sformatf("val n=%0d", n), o_val, exp_v);
        chk($sformatf("ovf n=%0d", n), o_ovf, exp_o);
        if (start_done) begin
            i_start = 1'b1; i_n = NW'(n ^ 1);
            @(posedge i_clk); #1;
            i_start = 1'b0;
            chk("start_in_done done", o_done, 1);
            chk("start_in_done val", o_val, exp_v);
        end
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_clear = 1'b0;
        chk("clear ready", o_ready, 1);
        chk("clear done", o_done, 0);
        chk("clear val_kept", o_val, exp_v);
        chk("clear ovf_kept", o_ovf, exp_o);
    endtask

    initial begin
        int            cyc;
        logic [DW-1:0] exp2;
        i_rst = 1'b1; i_start = 0; i_clear = 0; i_load = 0; i_n = '0; i_load_idx = '0; i_load_val = '0;
        b_start = 0; b_clear = 0; b_load = 0; b_n = '0; b_idx = '0; b_lval = '0;
        for (int k = 0; k < 4; k++) begin m_init[k] = '0; m2_init[k] = '0; end
        #12;
        chk("rst val", o_val, 0);
        chk("rst ready", o_ready, 1);
        chk("rst done", o_done, 0);
        chk("rst ovf", o_ovf, 0);
        @(negedge i_clk); i_rst = 1'b0;

        // ORDER=2 instance: index 3 must not land anywhere.
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            m2_init[k] = DW'($urandom_range(0, 15));
            b_load = 1'b1; b_idx = IW'(k); b_lval = m2_init[k];
        end
        @(negedge i_clk); b_idx = 2'd3; b_lval = 16'hFFFF;
        @(negedge i_clk); b_load = 1'b0;
        b_n = NW'($urandom_range(2, 20));
        exp2 = diff_at(int'(b_n), 0, 2, m2_init);
        b_start = 1'b1;
        @(negedge i_clk); b_start = 1'b0;
        cyc = 0;
        while (!b_done && cyc < 100) begin @(negedge i_clk); cyc++; end
        chk("ord2 done", b_done, 1);
        chk("ord2 idx3_ignored val", b_val, exp2);
        chk("ord2 ovf", b_ovf, 0);

        // 2n^2+3n+5
        do_load(0, 16'd5); do_load(1, 16'd5); do_load(2, 16'd4); do_load(3, 16'd0);
        run_eval(10, 0, 1, 0);
        chk("quad n=10 const", o_val, 235);
        run_eval(63, 1, 0, 0);
        chk("quad n=63 const", o_val, 8132);
        run_eval(0, 0, 0, 0);
        chk("quad n=0 const", o_val, 5);
        run_eval(1, 0, 0, 1);
        chk("quad n=1 const", o_val, 10);
        run_eval(2, 0, 0, 0);

        // n^3
        do_load(0, 16'd0); do_load(1, 16'd1); do_load(2, 16'd6); do_load(3, 16'd6);
        run_eval(5, 0, 0, 0);
        chk("cube n=5 const", o_val, 125);
        run_eval(40, 0, 0, 0);
        chk("cube n=40 const", o_val, 64000);
        run_eval(41, 0, 0, 0);
`ifdef BAB_SAT_EN
        chk("cube n=41 const", o_val, 65535);
`else
        chk("cube n=41 const", o_val, 3385);
`endif
        chk("cube n=41 ovf", o_ovf, 1);
        run_eval(2, 0, 0, 0);
        chk("cube n=2 const", o_val, 8);
        chk("cube n=2 ovf_cleared", o_ovf, 0);

        // Random small columns: no carries in either build.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k <= ORD; k++) do_load(k, DW'($urandom_range(0, 15)));
            run_eval(int'($urandom_range(0, 20)), r[0], r[1], r[2]);
        end
`ifndef BAB_SAT_EN
        // Random full-range columns exercise wrap-around and the sticky flag.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k <= ORD; k++) do_load(k, DW'($urandom));
            run_eval(int'($urandom_range(0, 63)), 0, 0, 0);
        end
`endif

        // Reset mid-evaluation; o_val is non-zero beforehand.
        do_load(0, 16'd7);
        run_eval(0, 0, 0, 0);
        @(negedge i_clk);
        i_start = 1'b1; i_n = NW'(50);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (20) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst val", o_val, 0);
        chk("midrst ready", o_ready, 1);
        chk("midrst done", o_done, 0);
        @(negedge i_clk); i_rst = 1'b0;
        for (int k = 0; k < 4; k++) m_init[k] = '0;
        run_eval(3, 0, 0, 0);
        chk("midrst init_zero", o_val, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
